// File: rtl/mem_req_arbiter.sv
// Arbitrates ring memory ops and display refill reads onto the DDR AF/WB and tags reads to route RB returns.
// Issue strobes are combinational from state (0 cycles); returns appear 1 cycle after the RB pop; AF/WB full and the outstanding limit stall issue.
module mem_req_arbiter #(
  parameter int DC_MAX_WAIT     = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inhibit,
  input  logic         ringReqValid,
  input  logic         ringReqWrite,
  input  logic [25:0]  ringReqAddr,
  input  logic [3:0]   ringReqDest,
  output logic         ringReqAck,
  input  logic         wdValid,
  input  logic [127:0] wdData,
  output logic         wdAck,
  input  logic         dcReq,
  input  logic [25:0]  dcAddr,
  output logic         dcAck,
  input  logic         afFull,
  input  logic         wbFull,
  output logic         wrAF,
  output logic [25:0]  afAddress,
  output logic         afRead,
  output logic         wrWB,
  output logic [127:0] wbData,
  input  logic         rbEmpty,
  input  logic [127:0] readData,
  output logic         rdRB,
  output logic         rdValid,
  output logic [127:0] rdData,
  output logic [3:0]   rdDest,
  output logic         rdToDC,
  output logic         stopped,
  output logic         protoErr
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = (DC_MAX_WAIT > 0) ? $clog2(DC_MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {STOP = 2'd0, RUN = 2'd1, DRAIN = 2'd2} stateT;

  typedef struct packed {
    logic       toDC;
    logic [3:0] dest;
  } tagT;

  stateT         state, stateNext;
  logic [OW-1:0] outstanding, outstandingNext;
  logic [SW-1:0] starve;
  logic          running, canRead;
  logic          ringRdElig, ringWrElig, ringElig, dcElig;
  logic          grantDc, grantRing, issueRead, popRb;
  tagT           pushTag, headTag;
  logic          tagEmpty, tagFull;

  // Reset also gates the strobes so every issue/pop output is low while reset is held.
  assign running    = (state == RUN) & ~reset;
  assign canRead    = (outstanding < OW'(MAX_OUTSTANDING)) & ~tagFull;
  assign ringRdElig = running & ringReqValid & ~ringReqWrite & ~afFull & canRead;
  assign ringWrElig = running & ringReqValid & ringReqWrite & wdValid & ~afFull & ~wbFull;
  assign ringElig   = ringRdElig | ringWrElig;
  assign dcElig     = running & dcReq & ~afFull & canRead;

  assign grantDc   = dcElig & ~(ringElig & (starve == SW'(DC_MAX_WAIT)));
  assign grantRing = ringElig & ~grantDc;
  assign issueRead = grantDc | (grantRing & ~ringReqWrite);
  assign popRb     = ~reset & ~rbEmpty & (outstanding != '0) & ~tagEmpty;

  assign pushTag = grantDc ? tagT'{toDC: 1'b1, dest: 4'd0} : tagT'{toDC: 1'b0, dest: ringReqDest};

  always_comb begin
    outstandingNext = outstanding;
    unique case ({issueRead, popRb})
      2'b10:   outstandingNext = outstanding + 1'b1;
      2'b01:   outstandingNext = outstanding - 1'b1;
      default: outstandingNext = outstanding;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= STOP;
    else       state <= stateNext;
  end

  // DRAIN looks at the post-update count so STOP is reached the cycle after the last pop.
  always_comb begin
    stateNext = state;
    unique case (state)
      STOP:    if (!inhibit) stateNext = RUN;
      RUN:     if (inhibit) stateNext = DRAIN;
      DRAIN:   if (outstandingNext == '0) stateNext = STOP;
      default: stateNext = STOP;
    endcase
  end

  always_comb begin
    stopped    = (state == STOP) | reset;
    dcAck      = grantDc;
    ringReqAck = grantRing;
    wdAck      = grantRing & ringReqWrite;
    wrAF       = grantDc | grantRing;
    afRead     = issueRead;
    afAddress  = '0;
    if (grantDc)        afAddress = dcAddr;
    else if (grantRing) afAddress = ringReqAddr;
    wrWB       = grantRing & ringReqWrite;
    wbData     = (grantRing & ringReqWrite) ? wdData : '0;
    rdRB       = popRb;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding <= '0;
      starve      <= '0;
      rdValid     <= 1'b0;
      rdData      <= '0;
      rdDest      <= '0;
      rdToDC      <= 1'b0;
      protoErr    <= 1'b0;
    end else begin
      outstanding <= outstandingNext;
      if (ringElig & grantDc) begin
        if (starve != SW'(DC_MAX_WAIT)) starve <= starve + 1'b1;
      end else begin
        starve <= '0;
      end
      rdValid <= popRb;
      if (popRb) begin
        rdData <= readData;
        rdDest <= headTag.dest;
        rdToDC <= headTag.toDC;
      end
      if (~rbEmpty & (outstanding == '0)) protoErr <= 1'b1;
    end
  end

  mem_req_arbiter_fifo #(.WIDTH($bits(tagT)), .DEPTH(MAX_OUTSTANDING)) tagFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (issueRead),
    .pushData (pushTag),
    .pop      (popRb),
    .popData  (headTag),
    .empty    (tagEmpty),
    .full     (tagFull)
  );
endmodule

// Generic first-word-fall-through FIFO; push when full and pop when empty are ignored.
module mem_req_arbiter_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [CW-1:0]    count;
  logic             doPush, doPop;

  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign popData = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      unique case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: DDR read-buffer model plus a return scoreboard checked on every rdValid.
module tb_mem_req_arbiter;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         inhibit = 1'b1;
  logic         ringReqValid = 1'b0, ringReqWrite = 1'b0;
  logic [25:0]  ringReqAddr = '0;
  logic [3:0]   ringReqDest = '0;
  logic         wdValid = 1'b0;
  logic [127:0] wdData = '0;
  logic         dcReq = 1'b0;
  logic [25:0]  dcAddr = '0;
  logic         afFull = 1'b0, wbFull = 1'b0;
  logic         rbEmpty = 1'b1;
  logic [127:0] readData = '0;

  logic         ringReqAck, wdAck, dcAck, wrAF, afRead, wrWB, rdRB, rdValid, rdToDC, stopped, protoErr;
  logic [25:0]  afAddress;
  logic [127:0] wbData, rdData;
  logic [3:0]   rdDest;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        toDC;
    logic [3:0]  dest;
    logic [25:0] addr;
  } expT;

  expT         expQ[$];
  logic [25:0] rbQ[$];
  bit          rbEnable = 1'b1;
  bit          rbForce = 1'b0;
  bit          chkRet = 1'b1;

  mem_req_arbiter dut (
    .clock(clock), .reset(reset), .inhibit(inhibit),
    .ringReqValid(ringReqValid), .ringReqWrite(ringReqWrite), .ringReqAddr(ringReqAddr),
    .ringReqDest(ringReqDest), .ringReqAck(ringReqAck),
    .wdValid(wdValid), .wdData(wdData), .wdAck(wdAck),
    .dcReq(dcReq), .dcAddr(dcAddr), .dcAck(dcAck),
    .afFull(afFull), .wbFull(wbFull),
    .wrAF(wrAF), .afAddress(afAddress), .afRead(afRead),
    .wrWB(wrWB), .wbData(wbData),
    .rbEmpty(rbEmpty), .readData(readData), .rdRB(rdRB),
    .rdValid(rdValid), .rdData(rdData), .rdDest(rdDest), .rdToDC(rdToDC),
    .stopped(stopped), .protoErr(protoErr)
  );

  always #5 clock = ~clock;

  // DDR side: every AF read returns its address as line data, in order.
  always @(posedge clock) begin
    if (reset) rbQ.delete();
    else begin
      if (rdRB && rbQ.size() > 0) void'(rbQ.pop_front());
      if (wrAF && afRead) rbQ.push_back(afAddress);
    end
    #2;
    rbEmpty  = !(rbForce || (rbEnable && rbQ.size() > 0));
    readData = (rbQ.size() > 0) ? {102'h0, rbQ[0]} : '0;
  end

  always @(negedge clock) begin
    if (rdValid && chkRet) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL ret_unexpected: rdValid with dest=%0d toDC=%0b, none expected", rdDest, rdToDC);
      end else begin
        expT e;
        e = expQ.pop_front();
        if ({rdToDC, rdDest, rdData} !== {e.toDC, e.dest, 102'h0, e.addr}) begin
          errors++;
          $display("FAIL ret: got toDC=%0b dest=%0d data=%h, want toDC=%0b dest=%0d addr=%h",
                   rdToDC, rdDest, rdData, e.toDC, e.dest, e.addr);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic waitReturns();
    for (int k = 0; k < 40 && expQ.size() != 0; k++) cyc();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL ret_timeout: %0d returns missing, want 0", expQ.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    #2;
    checks++;
    if ({stopped, wrAF, dcAck, ringReqAck, rdRB, rdValid, protoErr} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 1000000", {stopped, wrAF, dcAck, ringReqAck, rdRB, rdValid, protoErr});
    end
    cyc();
    reset = 1'b0;
    inhibit = 1'b0;
    #2;
    checks++;
    if (stopped !== 1'b1) begin errors++; $display("FAIL stop_after_reset: got %b want 1", stopped); end
    cyc();
    #2;
    checks++;
    if (stopped !== 1'b0) begin errors++; $display("FAIL run_entry: stopped got %b want 0", stopped); end
  endtask

  task automatic test_display();
    rbEnable = 1'b0;
    cyc();
    dcReq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dcAddr = 26'h100 + 26'(i);
      #2;
      checks++;
      if ({dcAck, wrAF, afRead, afAddress} !== {3'b111, 26'h100 + 26'(i)}) begin
        errors++;
        $display("FAIL dc_issue%0d: ack/af/rd=%b%b%b addr=%h want 111 addr=%h", i, dcAck, wrAF, afRead, afAddress, 26'h100 + 26'(i));
      end
      expQ.push_back(expT'{toDC: 1'b1, dest: 4'd0, addr: 26'h100 + 26'(i)});
      cyc();
    end
    dcAddr = 26'h108;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (dcAck !== 1'b0) begin errors++; $display("FAIL dc_limit%0d: dcAck got %b want 0", i, dcAck); end
      cyc();
    end
    rbEnable = 1'b1;
    #2;
    checks++;
    if ({rdRB, dcAck} !== 2'b10) begin
      errors++;
      $display("FAIL dc_first_pop: rdRB/dcAck got %b%b want 10", rdRB, dcAck);
    end
    cyc();
    #2;
    checks++;
    if (dcAck !== 1'b1) begin errors++; $display("FAIL dc_ninth: dcAck got %b want 1", dcAck); end
    expQ.push_back(expT'{toDC: 1'b1, dest: 4'd0, addr: 26'h108});
    cyc();
    dcReq = 1'b0;
    waitReturns();
  endtask

  task automatic test_starvation();
    chkRet = 1'b0;
    dcReq = 1'b1;
    dcAddr = 26'h300;
    ringReqValid = 1'b1;
    ringReqWrite = 1'b0;
    ringReqAddr = 26'h200;
    ringReqDest = 4'd3;
    for (int k = 0; k < 34; k++) begin
      logic wantRing;
      wantRing = ((k % 17) == 16);
      #2;
      checks++;
      if ({dcAck, ringReqAck} !== {~wantRing, wantRing}) begin
        errors++;
        $display("FAIL starve_cycle%0d: dcAck/ringReqAck got %b%b want %b%b", k, dcAck, ringReqAck, ~wantRing, wantRing);
      end
      cyc();
    end
    dcReq = 1'b0;
    ringReqValid = 1'b0;
    repeat (5) cyc();
    expQ.delete();
    chkRet = 1'b1;
  endtask

  task automatic test_ring_write();
    ringReqValid = 1'b1;
    ringReqWrite = 1'b1;
    ringReqAddr = 26'h0AB;
    wdData = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    wdValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++;
      if ({ringReqAck, wrAF, wrWB} !== 3'b000) begin
        errors++;
        $display("FAIL wr_nodata%0d: ack/wrAF/wrWB got %b%b%b want 000", i, ringReqAck, wrAF, wrWB);
      end
      cyc();
    end
    wdValid = 1'b1;
    #2;
    checks++;
    if ({wrAF, wrWB, ringReqAck, wdAck, afRead, afAddress, wbData} !==
        {5'b11110, 26'h0AB, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D}) begin
      errors++;
      $display("FAIL wr_issue: strobes=%b%b%b%b%b addr=%h data=%h want 11110 addr=0ab", wrAF, wrWB, ringReqAck, wdAck, afRead, afAddress, wbData);
    end
    cyc();
    ringReqValid = 1'b0;
    wdValid = 1'b0;
    #2;
    checks++;
    if (wrAF !== 1'b0) begin errors++; $display("FAIL wr_single: wrAF got %b want 0", wrAF); end
    cyc();
  endtask

  task automatic test_backpressure();
    afFull = 1'b1;
    dcReq = 1'b1;
    dcAddr = 26'h3C0;
    ringReqValid = 1'b1;
    ringReqWrite = 1'b0;
    ringReqDest = 4'd2;
    for (int i = 0; i < 10; i++) begin
      #2;
      checks++;
      if ({dcAck, ringReqAck, wrAF} !== 3'b000) begin
        errors++;
        $display("FAIL bp_full%0d: dcAck/ringReqAck/wrAF got %b%b%b want 000", i, dcAck, ringReqAck, wrAF);
      end
      cyc();
    end
    afFull = 1'b0;
    #2;
    checks++;
    if ({dcAck, ringReqAck} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: dcAck/ringReqAck got %b%b want 10", dcAck, ringReqAck);
    end
    expQ.push_back(expT'{toDC: 1'b1, dest: 4'd0, addr: 26'h3C0});
    cyc();
    dcReq = 1'b0;
    ringReqValid = 1'b0;
    waitReturns();
  endtask

  task automatic test_drain();
    rbEnable = 1'b0;
    ringReqValid = 1'b1;
    ringReqWrite = 1'b0;
    ringReqDest = 4'd7;
    for (int i = 0; i < 3; i++) begin
      ringReqAddr = 26'h40 + 26'(i);
      if (i == 2) inhibit = 1'b1;
      #2;
      checks++;
      if (ringReqAck !== 1'b1) begin errors++; $display("FAIL drain_issue%0d: ringReqAck got %b want 1", i, ringReqAck); end
      expQ.push_back(expT'{toDC: 1'b0, dest: 4'd7, addr: 26'h40 + 26'(i)});
      cyc();
    end
    ringReqAddr = 26'h43;
    dcReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({dcAck, ringReqAck, wrAF, stopped} !== 4'b0000) begin
        errors++;
        $display("FAIL drain_hold%0d: dcAck/ringReqAck/wrAF/stopped got %b%b%b%b want 0000", i, dcAck, ringReqAck, wrAF, stopped);
      end
      cyc();
    end
    dcReq = 1'b0;
    ringReqValid = 1'b0;
    rbEnable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({rdRB, stopped} !== 2'b10) begin
        errors++;
        $display("FAIL drain_pop%0d: rdRB/stopped got %b%b want 10", i, rdRB, stopped);
      end
      cyc();
    end
    inhibit = 1'b0;
    #2;
    checks++;
    if (stopped !== 1'b1) begin errors++; $display("FAIL drain_stop: stopped got %b want 1", stopped); end
    cyc();
    #2;
    checks++;
    if (stopped !== 1'b0) begin errors++; $display("FAIL drain_restart: stopped got %b want 0", stopped); end
    waitReturns();
  endtask

  task automatic test_mixed_and_error();
    ringReqWrite = 1'b0;
    ringReqDest = 4'd5;
    for (int i = 0; i < 6; i++) begin
      bit isDc;
      isDc = (i % 2) == 0;
      dcReq = isDc;
      dcAddr = 26'h500 + 26'(i);
      ringReqValid = !isDc;
      ringReqAddr = 26'h600 + 26'(i);
      #2;
      checks++;
      if ({dcAck, ringReqAck} !== {isDc, !isDc}) begin
        errors++;
        $display("FAIL mix_issue%0d: dcAck/ringReqAck got %b%b want %b%b", i, dcAck, ringReqAck, isDc, !isDc);
      end
      if (isDc) expQ.push_back(expT'{toDC: 1'b1, dest: 4'd0, addr: 26'h500 + 26'(i)});
      else      expQ.push_back(expT'{toDC: 1'b0, dest: 4'd5, addr: 26'h600 + 26'(i)});
      cyc();
    end
    dcReq = 1'b0;
    ringReqValid = 1'b0;
    waitReturns();
    repeat (2) cyc();
    #2;
    checks++;
    if (protoErr !== 1'b0) begin errors++; $display("FAIL err_clear: protoErr got %b want 0", protoErr); end
    cyc();
    rbForce = 1'b1;
    #2;
    checks++;
    if (rdRB !== 1'b0) begin errors++; $display("FAIL err_nopop: rdRB got %b want 0", rdRB); end
    cyc();
    rbForce = 1'b0;
    #2;
    checks++;
    if (protoErr !== 1'b1) begin errors++; $display("FAIL err_set: protoErr got %b want 1", protoErr); end
    repeat (2) cyc();
    #2;
    checks++;
    if (protoErr !== 1'b1) begin errors++; $display("FAIL err_sticky: protoErr got %b want 1", protoErr); end
    cyc();
    reset = 1'b1;
    cyc();
    #2;
    checks++;
    if ({protoErr, stopped, rdValid} !== 3'b010) begin
      errors++;
      $display("FAIL err_reset: protoErr/stopped/rdValid got %b want 010", {protoErr, stopped, rdValid});
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_starvation();
    test_ring_write();
    test_backpressure();
    test_drain();
    test_mixed_and_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
